// File: rtl/fifo_i2c_master_tx_pkg.sv
// Shared types and constants for the FIFO-fed I2C master-write transmitter.
package i2c_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_CHK,
    ST_FETCH,
    ST_LOAD,
    ST_DATA,
    ST_STOP
  } i2c_tx_state_e;

  typedef enum logic [1:0] {
    P0,
    P1,
    P2,
    P3
  } i2c_phase_e;

  localparam logic I2C_WRITE_BIT = 1'b0;
  localparam logic I2C_ACK       = 1'b0;
  localparam int   PRESCALE_W    = 8;

endpackage

// File: rtl/fifo_i2c_master_tx_bit_timer.sv
// Quarter-bit prescaler plus 2-bit phase counter; tick marks the last cycle of a phase.
module i2c_bit_timer
  import i2c_tx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  output logic       o_tick,
  output i2c_phase_e o_phase
);

  logic [PRESCALE_W-1:0] r_cnt;
  i2c_phase_e            r_phase;

  assign o_tick  = (r_cnt == PRESCALE_W'(CLK_DIV - 1));
  assign o_phase = r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= P0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_phase <= P0;
    end else if (o_tick) begin
      r_cnt   <= '0;
      r_phase <= i2c_phase_e'(r_phase + 2'd1);
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_i2c_master_tx.sv
// Drains byte_count bytes from the FIFO read port and sends them as one I2C master write.
module fifo_i2c_master_tx
  import i2c_tx_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int CLK_DIV  = 4
) (
  input  logic                rd_clk,
  input  logic                rrst_n,
  input  logic                start,
  input  logic [6:0]          slave_addr,
  input  logic [7:0]          byte_count,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rd_en,
  output logic                scl_oe,
  output logic                sda_oe,
  input  logic                sda_i,
  output logic                busy,
  output logic                done,
  output logic                nack_err,
  output i2c_tx_state_e       dbg_state
);

  i2c_tx_state_e r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_remaining;
  logic          r_ack_bit;
  logic          r_nack_seen;
  logic          r_stop_ext;
  logic          r_rd_en;
  logic          r_scl_oe;
  logic          r_sda_oe;
  logic          r_busy;
  logic          r_done;
  logic          r_nack_err;

  logic          w_tick;
  i2c_phase_e    w_phase;
  logic          w_clr;

  // Phase timing restarts from P0 whenever a timed state is entered from an untimed one.
  assign w_clr = (r_state == ST_IDLE) || (r_state == ST_FETCH) || (r_state == ST_LOAD);

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk   (rd_clk),
    .i_rst_n (rrst_n),
    .i_clr   (w_clr),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

  assign rd_en     = r_rd_en;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign done      = r_done;
  assign nack_err  = r_nack_err;
  assign dbg_state = r_state;

  // FIFO handshake: rempty=0 means a word is available; rd_en high for one cycle pops it
  // and rdata is valid the following cycle. Only this block reads, so rempty cannot rise
  // between the cycle it is sampled low and the cycle rd_en is driven.
  always_ff @(posedge rd_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_remaining <= '0;
      r_ack_bit   <= 1'b0;
      r_nack_seen <= 1'b0;
      r_stop_ext  <= 1'b0;
      r_rd_en     <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_nack_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_START;
            r_shift     <= {slave_addr, I2C_WRITE_BIT};
            r_remaining <= byte_count;
            r_bit_cnt   <= '0;
            r_nack_seen <= 1'b0;
            r_nack_err  <= 1'b0;
            r_stop_ext  <= 1'b0;
            r_busy      <= 1'b1;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick && w_phase == P1) r_sda_oe <= 1'b1;
          if (w_tick && w_phase == P3) begin
            r_state  <= ST_ADDR;
            r_scl_oe <= 1'b1;
            r_sda_oe <= ~r_shift[7];
          end
        end
        ST_ADDR, ST_DATA: begin
          if (w_tick && w_phase == P1) r_scl_oe <= 1'b0;
          if (w_tick && w_phase == P3) begin
            r_scl_oe <= 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state  <= ST_ACK_CHK;
              r_sda_oe <= 1'b0;
            end else begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_sda_oe  <= ~r_shift[6];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_ACK_CHK: begin
          if (w_tick && w_phase == P1) r_scl_oe <= 1'b0;
          if (w_tick && w_phase == P2) r_ack_bit <= sda_i;
          if (w_tick && w_phase == P3) begin
            r_scl_oe <= 1'b1;
            r_sda_oe <= 1'b1;
            if (r_ack_bit != I2C_ACK) begin
              r_nack_seen <= 1'b1;
              r_state     <= ST_STOP;
            end else if (r_remaining != 8'd0) begin
              r_state <= ST_FETCH;
              r_rd_en <= ~rempty;
            end else begin
              r_state <= ST_STOP;
            end
          end
        end
        ST_FETCH: begin
          if (r_rd_en) begin
            r_rd_en <= 1'b0;
            r_state <= ST_LOAD;
          end else if (!rempty) begin
            r_rd_en <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_shift     <= rdata[7:0];
          r_sda_oe    <= ~rdata[7];
          r_remaining <= r_remaining - 8'd1;
          r_bit_cnt   <= '0;
          r_state     <= ST_DATA;
        end
        ST_STOP: begin
          // Five quarter-bits: P0 low/low, P1-P2 SCL high, P3 plus one extra P0 SDA high.
          if (w_tick && w_phase == P0) begin
            if (r_stop_ext) begin
              r_state    <= ST_IDLE;
              r_stop_ext <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_nack_err <= r_nack_seen;
            end else begin
              r_scl_oe <= 1'b0;
            end
          end
          if (w_tick && w_phase == P2) r_sda_oe   <= 1'b0;
          if (w_tick && w_phase == P3) r_stop_ext <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_i2c_master_tx.sv
// Bench for fifo_i2c_master_tx: FIFO model, I2C bus monitor/slave and byte scoreboard.
module tb_fifo_i2c_master_tx;
  import i2c_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic rd_clk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 rd_clk = ~rd_clk;

  logic          start      = 1'b0;
  logic [6:0]    slave_addr = '0;
  logic [7:0]    byte_count = '0;
  logic          rempty     = 1'b1;
  logic [7:0]    rdata      = '0;
  logic          sda_i;
  logic          rd_en, scl_oe, sda_oe, busy, done, nack_err;
  i2c_tx_state_e dbg_state;

  logic slave_pull = 1'b0;
  assign sda_i = ~(sda_oe | slave_pull);

  fifo_i2c_master_tx #(.DATASIZE(8), .CLK_DIV(4)) dut (
    .rd_clk     (rd_clk),
    .rrst_n     (rrst_n),
    .start      (start),
    .slave_addr (slave_addr),
    .byte_count (byte_count),
    .rempty     (rempty),
    .rdata      (rdata),
    .rd_en      (rd_en),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_i      (sda_i),
    .busy       (busy),
    .done       (done),
    .nack_err   (nack_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] fifo_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  always @(posedge rd_clk) begin
    if (rrst_n && rd_en) begin
      if (fifo_q.size() > 0) rdata <= fifo_q.pop_front();
      rempty <= (fifo_q.size() == 0);
    end
  end

  task automatic fifo_push(input logic [7:0] b);
    fifo_q.push_back(b);
    rempty = 1'b0;
  endtask

  task automatic fifo_flush();
    fifo_q.delete();
    rempty = 1'b1;
  endtask

  // ---------------- bus monitor + slave ----------------
  logic       prev_scl = 1'b1, prev_sda = 1'b1, scl_l, sda_l;
  logic [7:0] mon_sh = '0;
  logic [7:0] mon_exp;
  int bitn = 0, byte_idx = 0, n_bytes = 0, n_start = 0, n_stop = 0, nack_idx = -1;
  int busy_cyc = 0, done_cnt = 0, rd_cnt = 0, viol_cnt = 0;

  always @(negedge rd_clk) begin
    scl_l = ~scl_oe;
    sda_l = sda_i;
    if (!rrst_n) begin
      bitn       = 0;
      slave_pull = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (rd_en) rd_cnt++;
      if (rd_en && rempty) viol_cnt++;
      if (scl_l && prev_scl && prev_sda && !sda_l) begin
        n_start++;
        bitn     = 0;
        byte_idx = 0;
      end else if (scl_l && prev_scl && !prev_sda && sda_l) begin
        n_stop++;
      end
      if (scl_l && !prev_scl) begin
        if (bitn < 8) begin
          mon_sh = {mon_sh[6:0], sda_l};
          bitn++;
        end else begin
          check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("bus_byte", 32'(mon_sh), 32'(mon_exp));
          end
          check("ack_bit", 32'(sda_l), 32'(byte_idx == nack_idx));
          byte_idx++;
          n_bytes++;
          bitn = 0;
        end
      end
      if (!scl_l && prev_scl) slave_pull = (bitn == 8) && (byte_idx != nack_idx);
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counters();
    busy_cyc = 0; done_cnt = 0; rd_cnt = 0; viol_cnt = 0;
    n_bytes = 0; n_start = 0; n_stop = 0;
  endtask

  task automatic pulse_start(input logic [6:0] a, input logic [7:0] c);
    @(negedge rd_clk);
    slave_addr = a;
    byte_count = c;
    start      = 1'b1;
    @(negedge rd_clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge rd_clk); #1;
      if (done_cnt > 0) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    repeat (5) @(negedge rd_clk);
    #1;
  endtask

  task automatic basic_txn(input string tag);
    fifo_flush();
    fifo_push(8'hA5);
    fifo_push(8'h3C);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    nack_idx = -1;
    clear_counters();
    pulse_start(7'h50, 8'd2);
    wait_done(3000);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd2);
    check({tag, "_busy_cyc"}, 32'(busy_cyc), 32'd472);
    check({tag, "_nack_err"}, 32'(nack_err), 32'd0);
    check({tag, "_bytes"}, 32'(n_bytes), 32'd3);
    check({tag, "_starts"}, 32'(n_start), 32'd1);
    check({tag, "_stops"}, 32'(n_stop), 32'd1);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_fifo_left"}, 32'(fifo_q.size()), 32'd0);
    check({tag, "_rd_empty"}, 32'(viol_cnt), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int stall_bad;
    bit hit;

    repeat (3) @(negedge rd_clk);
    #1;
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_nack", 32'(nack_err), 32'd0);
    @(negedge rd_clk);
    rrst_n = 1'b1;
    repeat (3) @(negedge rd_clk);
    #1;
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    basic_txn("basic");

    // Address NACK with three bytes waiting
    fifo_flush();
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
    exp_q.push_back(8'hA0);
    nack_idx = 0;
    clear_counters();
    pulse_start(7'h50, 8'd3);
    wait_done(3000);
    check("nack_rd_cnt", 32'(rd_cnt), 32'd0);
    check("nack_err", 32'(nack_err), 32'd1);
    check("nack_done_cnt", 32'(done_cnt), 32'd1);
    check("nack_fifo_left", 32'(fifo_q.size()), 32'd3);
    check("nack_busy_cyc", 32'(busy_cyc), 32'd180);
    check("nack_stops", 32'(n_stop), 32'd1);
    check("nack_exp_left", 32'(exp_q.size()), 32'd0);

    // Zero-length write
    fifo_flush();
    exp_q.push_back(8'hA0);
    nack_idx = -1;
    clear_counters();
    pulse_start(7'h50, 8'd0);
    #1;
    check("zero_nack_cleared", 32'(nack_err), 32'd0);
    wait_done(3000);
    check("zero_rd_cnt", 32'(rd_cnt), 32'd0);
    check("zero_done_cnt", 32'(done_cnt), 32'd1);
    check("zero_busy_cyc", 32'(busy_cyc), 32'd180);
    check("zero_starts", 32'(n_start), 32'd1);
    check("zero_stops", 32'(n_stop), 32'd1);
    check("zero_exp_left", 32'(exp_q.size()), 32'd0);

    // FIFO underflow stall after the address ACK
    fifo_flush();
    exp_q.push_back(8'h74);
    exp_q.push_back(8'h81);
    clear_counters();
    pulse_start(7'h3A, 8'd1);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge rd_clk); #1;
      if (n_bytes >= 1 && scl_oe) hit = 1'b1;
    end
    check("uf_addr_seen", 32'(hit), 32'd1);
    stall_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge rd_clk); #1;
      if (!scl_oe || rd_en) stall_bad++;
    end
    check("uf_stall_hold", 32'(stall_bad), 32'd0);
    check("uf_state", 32'(dbg_state), 32'(ST_FETCH));
    fifo_push(8'h81);
    wait_done(3000);
    check("uf_rd_cnt", 32'(rd_cnt), 32'd1);
    check("uf_done_cnt", 32'(done_cnt), 32'd1);
    check("uf_exp_left", 32'(exp_q.size()), 32'd0);
    check("uf_rd_empty", 32'(viol_cnt), 32'd0);

    // A second start while busy must be ignored
    fifo_flush();
    fifo_push(8'h5A);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h5A);
    clear_counters();
    pulse_start(7'h2B, 8'd1);
    repeat (40) @(negedge rd_clk);
    pulse_start(7'h11, 8'd4);
    wait_done(3000);
    repeat (300) @(negedge rd_clk);
    #1;
    check("dup_done_cnt", 32'(done_cnt), 32'd1);
    check("dup_starts", 32'(n_start), 32'd1);
    check("dup_busy_cyc", 32'(busy_cyc), 32'd326);
    check("dup_rd_cnt", 32'(rd_cnt), 32'd1);
    check("dup_exp_left", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of data bit 4
    fifo_flush();
    fifo_push(8'hA5);
    fifo_push(8'h3C);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    clear_counters();
    pulse_start(7'h50, 8'd2);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge rd_clk); #1;
      if (byte_idx == 1 && bitn == 4 && scl_oe) hit = 1'b1;
    end
    check("mid_bit4_seen", 32'(hit), 32'd1);
    #1;
    rrst_n = 1'b0;
    #1;
    check("mid_scl_oe", 32'(scl_oe), 32'd0);
    check("mid_sda_oe", 32'(sda_oe), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rd_en", 32'(rd_en), 32'd0);
    repeat (4) @(negedge rd_clk);
    exp_q.delete();
    rrst_n = 1'b1;
    repeat (4) @(negedge rd_clk);
    basic_txn("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_i2c_master_tx.md
# fifo_i2c_master_tx

Read-side consumer of the bridge's asynchronous FIFO, living entirely in the `rd_clk` domain. On a start command it drains a given number of bytes from the FIFO read port and transmits them as one I2C master-write transaction: START, 7-bit address + W, data bytes, STOP. It checks the ACK after every byte and stalls the bus, holding SCL low, whenever the FIFO runs dry.

## Interface
Parameters:
- `DATASIZE`, 8: FIFO word width; only 8 is supported.
- `CLK_DIV`, 4: `rd_clk` cycles per quarter SCL bit period. Legal range 2..255.

Ports:
- `rd_clk` in 1: the only clock.
- `rrst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle transaction request; sampled only in IDLE.
- `slave_addr` in 7: target address; captured when `start` is accepted.
- `byte_count` in 8: number of data bytes; captured when `start` is accepted; 0 is legal.
- `rempty` in 1: FIFO empty flag, already synchronized to `rd_clk`.
- `rdata` in DATASIZE: FIFO read data, valid on the cycle after an `rd_en` pulse.
- `rd_en` out 1: FIFO pop, one cycle per byte.
- `scl_oe` out 1: 1 pulls SCL low; 0 releases it (open drain).
- `sda_oe` out 1: 1 pulls SDA low; 0 releases it.
- `sda_i` in 1: sampled SDA line, already synchronized.
- `busy` out 1: high from start acceptance until the cycle that returns to IDLE.
- `done` out 1: one-cycle pulse on entry to IDLE at the end of a transaction.
- `nack_err` out 1: set with `done` when any NACK occurred; held until the next accepted `start`.

## Operation
- States: IDLE, START, ADDR, ACK_CHK, FETCH, LOAD, DATA, STOP.
- IDLE: `start`=1 → capture `slave_addr` and `byte_count`, clear `nack_err`, go to START.
- START condition:
  - SDA released, SCL released for 2·CLK_DIV cycles.
  - Then SDA low for 2·CLK_DIV cycles.
  - Then SCL low; go to ADDR.
- Bit cell for ADDR and DATA is 4 phases of CLK_DIV cycles each:
  - p0: SCL low, SDA updated MSB first.
  - p1: SCL low.
  - p2, p3: SCL released.
- ADDR shifts the byte `{slave_addr,1'b0}`.
- ACK_CHK is one bit cell with SDA released. `sda_i` is sampled on the last cycle of p2; 0 = ACK.
- After ACK_CHK:
  - NACK → set `nack_err`, go to STOP.
  - ACK and bytes remaining → FETCH.
  - ACK and none remaining → STOP.
- FETCH: SCL held low, SDA held low.
  - If `rempty`=0, assert `rd_en` for exactly one cycle, then go to LOAD.
  - If `rempty`=1, wait indefinitely with SCL held low.
- LOAD: latch `rdata` into the shift register, decrement the remaining count, go to DATA. DATA shifts 8 bits, then ACK_CHK.
- STOP condition:
  - SCL low, SDA low for CLK_DIV cycles.
  - SCL released for 2·CLK_DIV cycles.
  - SDA released for 2·CLK_DIV cycles.
  - Then IDLE, with `done` pulsed.
- On NACK no further `rd_en` is issued; unread bytes stay in the FIFO.
- `start` while busy is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE; `scl_oe`=0, `sda_oe`=0, `rd_en`=0, `busy`=0, `done`=0, `nack_err`=0; counters cleared.
- `start` accepted at edge N: `busy`=1 and state START from edge N+1.
- One byte + ACK = 9 bit cells = 36·CLK_DIV cycles.
- FETCH + LOAD with a non-empty FIFO = 2 cycles of extra SCL-low time per data byte.
- Total cycles with no stall = 4·CLK_DIV + 36·CLK_DIV·(1+byte_count) + 2·byte_count + 5·CLK_DIV.
- `rd_en` never asserts while `rempty`=1; it never asserts twice for one byte.
- Reset mid-transaction releases both lines immediately. No STOP is generated.

## Structure
- Package `i2c_tx_pkg`:
  - state enum `i2c_tx_state_e`;
  - phase enum (P0..P3);
  - constants `I2C_WRITE_BIT`=0 and `I2C_ACK`=0.
- Sub-module `i2c_bit_timer` (CLK_DIV prescaler + 2-bit phase counter, `tick`/`phase` outputs, synchronous clear). The FSM owns everything else.

## Test plan
- CLK_DIV=4; addr 0x50; count 2; FIFO preloaded A5, 3C; `sda_i` driven low at every ACK slot.
  - Required bus bytes: A0, A5, 3C, each ACKed, framed by START and STOP.
  - Exactly 2 `rd_en` pulses; `done` for one cycle at cycle 16+432+4+20; `nack_err`=0.
- Address NACK (`sda_i`=1 in the first ACK slot), count 3:
  - Zero `rd_en` pulses; STOP follows immediately; `nack_err`=1 with `done`; FIFO still holds 3 bytes.
- Underflow: count 1, FIFO empty for 200 cycles after the address ACK.
  - `scl_oe`=1 and `rd_en`=0 throughout the wait.
  - After writing 0x81, the transaction resumes and 0x81 appears on SDA MSB first.
- count 0: bus carries START, A0, ACK, STOP; no `rd_en`; `done` pulses.
- Second `start` pulsed while busy is ignored: exactly one transaction, one `done`.
- `rrst_n` asserted during DATA bit 4:
  - Same cycle: `scl_oe`, `sda_oe`, `busy`, `rd_en` all 0.
  - After release, a fresh `start` runs a full correct transaction.
